// File: rtl/urf_altitude_filter.sv
// Altitude de-glitch filter for the ultrasonic range finder: validity check,
// median-of-3, step-size outlier rejection and 4-tap moving average.
module urf_altitude_filter #(
    parameter int unsigned MAX_RANGE    = 400,
    parameter int unsigned MAX_STEP     = 20,
    parameter int unsigned REJECT_LIMIT = 3
) (
    input  logic       us_clk,
    input  logic       resetn,
    input  logic       active_signal,
    input  logic [9:0] urf_range,
    output logic [9:0] filt_range,
    output logic       filt_valid,
    output logic       filt_locked,
    output logic [7:0] reject_count,
    output logic [7:0] discard_count
);

    localparam logic [9:0]  MAX_RANGE_C = 10'(MAX_RANGE);
    localparam logic [10:0] MAX_STEP_C  = 11'(MAX_STEP);
    localparam logic [7:0]  REJ_LIM_C   = 8'(REJECT_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE, S_CAPTURE, S_MEDIAN, S_CHECK, S_AVERAGE, S_OUTPUT
    } state_t;

    state_t      state_q;
    logic        active_q;
    logic [9:0]  samp_q, med_q;
    logic [9:0]  r0_q, r1_q, r2_q;
    logic [9:0]  a0_q, a1_q, a2_q, a3_q;
    logic [7:0]  consec_q;
    logic [9:0]  filt_range_q;
    logic        filt_valid_q, filt_locked_q;
    logic [7:0]  reject_q, discard_q;

    logic        new_sample;
    logic [9:0]  med_c;
    logic [10:0] diff_c;
    logic [11:0] sum_c;
    logic [7:0]  consec_inc;

    assign new_sample = active_q & ~active_signal;
    assign consec_inc = consec_q + 8'd1;

    // Median of the raw buffer; ties naturally resolve to the repeated value.
    always_comb begin
        med_c = r2_q;
        if ((r0_q >= r1_q && r0_q <= r2_q) || (r0_q <= r1_q && r0_q >= r2_q))
            med_c = r0_q;
        else if ((r1_q >= r0_q && r1_q <= r2_q) || (r1_q <= r0_q && r1_q >= r2_q))
            med_c = r1_q;
    end

    always_comb begin
        diff_c = (med_q >= filt_range_q) ? 11'(med_q) - 11'(filt_range_q)
                                         : 11'(filt_range_q) - 11'(med_q);
        // Sum uses the post-shift buffer: med enters as the newest tap.
        sum_c  = 12'(med_q) + 12'(a0_q) + 12'(a1_q) + 12'(a2_q);
    end

    always_ff @(posedge us_clk) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            active_q      <= 1'b0;
            samp_q        <= '0;
            med_q         <= '0;
            r0_q          <= '0;
            r1_q          <= '0;
            r2_q          <= '0;
            a0_q          <= '0;
            a1_q          <= '0;
            a2_q          <= '0;
            a3_q          <= '0;
            consec_q      <= '0;
            filt_range_q  <= '0;
            filt_valid_q  <= 1'b0;
            filt_locked_q <= 1'b0;
            reject_q      <= '0;
            discard_q     <= '0;
        end else begin
            active_q     <= active_signal;
            filt_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (new_sample) begin
                        samp_q  <= urf_range;
                        state_q <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (samp_q == 10'd0 || samp_q > MAX_RANGE_C) begin
                        if (discard_q != 8'hFF) discard_q <= discard_q + 8'd1;
                        state_q <= S_IDLE;
                    end else if (!filt_locked_q) begin
                        r0_q          <= samp_q;
                        r1_q          <= samp_q;
                        r2_q          <= samp_q;
                        a0_q          <= samp_q;
                        a1_q          <= samp_q;
                        a2_q          <= samp_q;
                        a3_q          <= samp_q;
                        filt_range_q  <= samp_q;
                        filt_locked_q <= 1'b1;
                        consec_q      <= '0;
                        filt_valid_q  <= 1'b1;
                        state_q       <= S_OUTPUT;
                    end else begin
                        r2_q    <= r1_q;
                        r1_q    <= r0_q;
                        r0_q    <= samp_q;
                        state_q <= S_MEDIAN;
                    end
                end
                S_MEDIAN: begin
                    med_q   <= med_c;
                    state_q <= S_CHECK;
                end
                S_CHECK: begin
                    if (diff_c > MAX_STEP_C) begin
                        if (reject_q != 8'hFF) reject_q <= reject_q + 8'd1;
                        if (consec_inc >= REJ_LIM_C) begin
                            filt_locked_q <= 1'b0;
                            consec_q      <= '0;
                        end else begin
                            consec_q <= consec_inc;
                        end
                        state_q <= S_IDLE;
                    end else begin
                        consec_q <= '0;
                        state_q  <= S_AVERAGE;
                    end
                end
                S_AVERAGE: begin
                    a3_q         <= a2_q;
                    a2_q         <= a1_q;
                    a1_q         <= a0_q;
                    a0_q         <= med_q;
                    filt_range_q <= 10'(sum_c >> 2);
                    filt_valid_q <= 1'b1;
                    state_q      <= S_OUTPUT;
                end
                S_OUTPUT: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    assign filt_range    = filt_range_q;
    assign filt_valid    = filt_valid_q;
    assign filt_locked   = filt_locked_q;
    assign reject_count  = reject_q;
    assign discard_count = discard_q;

endmodule

// File: tb/tb_urf_altitude_filter.sv
// Randomized self-checking bench for urf_altitude_filter against a
// sample-level reference model (sorted median, list-based moving average).
module tb_urf_altitude_filter;

    logic       us_clk = 1'b0;
    logic       resetn;
    logic       active_signal;
    logic [9:0] urf_range;
    logic [9:0] filt_range;
    logic       filt_valid;
    logic       filt_locked;
    logic [7:0] reject_count;
    logic [7:0] discard_count;

    urf_altitude_filter dut (
        .us_clk        (us_clk),
        .resetn        (resetn),
        .active_signal (active_signal),
        .urf_range     (urf_range),
        .filt_range    (filt_range),
        .filt_valid    (filt_valid),
        .filt_locked   (filt_locked),
        .reject_count  (reject_count),
        .discard_count (discard_count)
    );

    always #5 us_clk = ~us_clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model state
    int m_raw[3];
    int m_avg[4];
    int m_filt, m_locked, m_consec, m_rej, m_disc;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_raw[i] = 0;
        for (int i = 0; i < 4; i++) m_avg[i] = 0;
        m_filt = 0; m_locked = 0; m_consec = 0; m_rej = 0; m_disc = 0;
    endtask

    // Returns expected strobe latency in cycles, 0 when no strobe.
    task automatic model_step(input int v, output int lat);
        int s[3];
        int t, med, diff, sum;
        lat = 0;
        if (v == 0 || v > 400) begin
            if (m_disc < 255) m_disc++;
        end else if (m_locked == 0) begin
            for (int i = 0; i < 3; i++) m_raw[i] = v;
            for (int i = 0; i < 4; i++) m_avg[i] = v;
            m_filt = v; m_locked = 1; m_consec = 0; lat = 2;
        end else begin
            m_raw[2] = m_raw[1]; m_raw[1] = m_raw[0]; m_raw[0] = v;
            s = m_raw;
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2 - i; j++)
                    if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
            med  = s[1];
            diff = (med > m_filt) ? med - m_filt : m_filt - med;
            if (diff > 20) begin
                if (m_rej < 255) m_rej++;
                m_consec++;
                if (m_consec == 3) begin m_locked = 0; m_consec = 0; end
            end else begin
                m_consec = 0;
                m_avg[3] = m_avg[2]; m_avg[2] = m_avg[1]; m_avg[1] = m_avg[0]; m_avg[0] = med;
                sum = m_avg[0] + m_avg[1] + m_avg[2] + m_avg[3];
                m_filt = sum / 4;
                lat = 5;
            end
        end
    endtask

    task automatic check_status(input string tag);
        check($sformatf("%s/range", tag),   int'(filt_range),    m_filt);
        check($sformatf("%s/locked", tag),  int'(filt_locked),   m_locked);
        check($sformatf("%s/rej", tag),     int'(reject_count),  m_rej);
        check($sformatf("%s/disc", tag),    int'(discard_count), m_disc);
    endtask

    // One falling edge of active_signal with urf_range = v, then watch 8 cycles.
    task automatic run_sample(input int v, input string tag);
        int lat, seen, strobes, frange;
        model_step(v, lat);
        @(negedge us_clk);
        urf_range     = 10'(v);
        active_signal = 1'b1;
        @(negedge us_clk);
        active_signal = 1'b0;
        seen = 0; strobes = 0; frange = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge us_clk);
            if (filt_valid) begin
                strobes++;
                if (seen == 0) seen = k;
                frange = int'(filt_range);
            end
        end
        check($sformatf("%s/lat", tag), seen, lat);
        check($sformatf("%s/strobes", tag), strobes, (lat != 0) ? 1 : 0);
        if (lat != 0) check($sformatf("%s/strobe_range", tag), frange, m_filt);
        check_status(tag);
    endtask

    // Tracked sample with reset asserted across the MEDIAN cycle.
    task automatic reset_in_median(input int v);
        int strobes;
        @(negedge us_clk);
        urf_range     = 10'(v);
        active_signal = 1'b1;
        @(negedge us_clk);
        active_signal = 1'b0;
        @(negedge us_clk);
        @(negedge us_clk);
        resetn = 1'b0;
        @(negedge us_clk);
        resetn = 1'b1;
        model_reset();
        strobes = int'(filt_valid);
        check_status("rst_mid");
        for (int k = 0; k < 6; k++) begin
            @(negedge us_clk);
            if (filt_valid) strobes++;
        end
        check("rst_mid/strobes", strobes, 0);
    endtask

    initial begin
        int v, kind;
        resetn        = 1'b0;
        active_signal = 1'b0;
        urf_range     = '0;
        model_reset();
        repeat (3) @(negedge us_clk);
        check("reset/valid", int'(filt_valid), 0);
        check_status("reset");
        resetn = 1'b1;

        run_sample(100, "prime");
        run_sample(104, "ramp0");
        run_sample(108, "ramp1");
        run_sample(112, "ramp2");
        run_sample(100, "settle");
        run_sample(100, "settle2");
        run_sample(300, "spike");
        run_sample(100, "post_spike");
        run_sample(120, "step_eq");
        for (int i = 0; i < 4; i++) run_sample(200, $sformatf("jump%0d", i));
        run_sample(200, "reprime");
        run_sample(0, "zero");
        run_sample(401, "over");
        run_sample(400, "maxvalid");
        reset_in_median(390);
        run_sample(150, "after_rst");

        for (int n = 0; n < 120; n++) begin
            kind = int'($urandom_range(0, 9));
            if (kind == 0)
                v = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(401, 1023));
            else if (kind == 1)
                v = int'($urandom_range(1, 400));
            else begin
                v = m_filt + int'($urandom_range(0, 50)) - 25;
                if (v < 1) v = 1;
                if (v > 400) v = 400;
            end
            run_sample(v, $sformatf("rnd%0d", n));
        end

        for (int n = 0; n < 260; n++) run_sample(1023, "disc_sat");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
